// File: rtl/iccm_boot_loader.sv
// ============================================================================
// iccm_boot_loader
//
// Loads a program image from the UART byte stream into one of several target
// memories, then releases the core from reset. It replaces the fixed-width
// ICCM controller.
//
// Frame on the wire:
//   SYNC, TARGET, LEN_LO, LEN_HI, LEN*BPW payload bytes (LSB first), CHK
//   CHK is the 8-bit wrapping sum of the payload bytes only.
//
// Payload bytes are packed into DataWidth-bit little-endian words. Each
// completed word is written to the latched target bank at consecutive word
// addresses starting from 0.
//
// The core is held in reset until a frame passes its checksum. A bad target,
// an oversized length, a bad checksum or an inter-byte timeout aborts the
// frame and raises a sticky error. Writes that already happened are not undone.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-high reset
//   rx_dv_i       one-cycle strobe: rx_byte_i is valid
//   rx_byte_i     received byte
//   we_o          one-cycle write strobe
//   bank_o        target bank of the write
//   addr_o        word address of the write
//   wdata_o       write data
//   core_reset_o  high = hold the core in reset
//   done_o        high = the last frame was accepted
//   err_o         sticky error flag; cleared by the next SYNC byte
// ============================================================================
module iccm_boot_loader #(
    parameter int         DataWidth     = 32,
    parameter int         AddrWidth     = 12,
    parameter int         NumBanks      = 2,
    parameter int         TimeoutCycles = 1048576,
    parameter logic [7:0] SyncByte      = 8'hA5,
    localparam int        BankWidth     = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_dv_i,
    input  logic [7:0]           rx_byte_i,
    output logic                 we_o,
    output logic [BankWidth-1:0] bank_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 core_reset_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int         BPW   = DataWidth / 8;
    localparam int         BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int         TCW   = $clog2(TimeoutCycles + 1);
    // Bank depth as a wide constant, so that the length check also works
    // when AddrWidth is 16 or more.
    localparam logic [32:0] DEPTH = 33'(1) << AddrWidth;

    typedef enum logic [2:0] {
        S_IDLE, S_TARGET, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t state_reg, state_next;

    logic [BankWidth-1:0] bank_lat_reg;
    logic [7:0]           len_lo_reg;
    logic [15:0]          words_left_reg;
    logic [AddrWidth-1:0] addr_cnt_reg;
    logic [BCW-1:0]       byte_cnt_reg;
    logic [DataWidth-1:0] word_reg;
    logic [7:0]           sum_reg;
    logic [TCW-1:0]       tmo_cnt_reg;

    logic                 we_reg;
    logic [BankWidth-1:0] bank_out_reg;
    logic [AddrWidth-1:0] addr_out_reg;
    logic [DataWidth-1:0] wdata_out_reg;
    logic                 core_reset_reg;
    logic                 done_reg;
    logic                 err_reg;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic                 is_sync;
    logic                 timed;
    logic                 timeout;
    logic                 last_lane;
    logic                 last_word;
    logic [15:0]          len_full;
    logic                 len_too_big;
    logic                 bad_target;
    logic [DataWidth-1:0] word_merged;

    assign is_sync     = (rx_byte_i == SyncByte);
    assign timed       = (state_reg == S_TARGET) || (state_reg == S_LEN0) ||
                         (state_reg == S_LEN1)   || (state_reg == S_DATA) ||
                         (state_reg == S_CHK);
    // tmo_cnt_reg holds (idle clocks since the last byte) - 1, so this fires
    // on the TimeoutCycles-th idle clock. A byte on that same clock wins.
    assign timeout     = timed && !rx_dv_i &&
                         (tmo_cnt_reg == TCW'(TimeoutCycles - 1));
    assign last_lane   = (byte_cnt_reg == BCW'(BPW - 1));
    assign last_word   = (words_left_reg == 16'd1);
    assign len_full    = {rx_byte_i, len_lo_reg};
    assign len_too_big = ({17'd0, len_full} > DEPTH);
    assign bad_target  = ({24'd0, rx_byte_i} >= 32'(NumBanks));

    // Current word with the incoming byte placed in the lane byte_cnt points
    // at. A completed word is written straight from here.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        assign word_merged[gi*8 +: 8] = (byte_cnt_reg == BCW'(gi)) ?
                                        rx_byte_i : word_reg[gi*8 +: 8];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (rx_dv_i && is_sync) state_next = S_TARGET;
            end
            S_TARGET: begin
                if (rx_dv_i) state_next = bad_target ? S_ERR : S_LEN0;
            end
            S_LEN0: begin
                if (rx_dv_i) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (rx_dv_i) begin
                    if (len_too_big)           state_next = S_ERR;
                    else if (len_full == 16'd0) state_next = S_CHK;
                    else                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_dv_i && last_lane && last_word) state_next = S_CHK;
            end
            S_CHK: begin
                if (rx_dv_i) state_next = (rx_byte_i == sum_reg) ? S_DONE : S_ERR;
            end
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (timeout) state_next = S_ERR;
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    logic start_frame;
    logic ld_bank;
    logic ld_len_lo;
    logic ld_len;
    logic data_byte;
    logic frame_ok;
    logic release_core;
    logic in_err;

    always_comb begin
        start_frame  = 1'b0;
        ld_bank      = 1'b0;
        ld_len_lo    = 1'b0;
        ld_len       = 1'b0;
        data_byte    = 1'b0;
        frame_ok     = 1'b0;
        release_core = 1'b0;
        in_err       = 1'b0;
        case (state_reg)
            S_IDLE:   start_frame = rx_dv_i && is_sync;
            S_TARGET: ld_bank     = rx_dv_i && !bad_target;
            S_LEN0:   ld_len_lo   = rx_dv_i;
            S_LEN1:   ld_len      = rx_dv_i;
            S_DATA:   data_byte   = rx_dv_i;
            S_CHK:    frame_ok    = rx_dv_i && (rx_byte_i == sum_reg);
            S_DONE: begin
                start_frame  = rx_dv_i && is_sync;
                // Release the core on the cycle after entry into DONE,
                // unless a new frame is already starting.
                release_core = !(rx_dv_i && is_sync);
            end
            S_ERR:    in_err      = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_lat_reg   <= '0;
            len_lo_reg     <= '0;
            words_left_reg <= '0;
            addr_cnt_reg   <= '0;
            byte_cnt_reg   <= '0;
            word_reg       <= '0;
            sum_reg        <= '0;
            tmo_cnt_reg    <= '0;
            we_reg         <= 1'b0;
            bank_out_reg   <= '0;
            addr_out_reg   <= '0;
            wdata_out_reg  <= '0;
            core_reset_reg <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            we_reg      <= 1'b0;
            tmo_cnt_reg <= (timed && !rx_dv_i) ? tmo_cnt_reg + 1'b1 : '0;

            if (start_frame) begin
                err_reg        <= 1'b0;
                done_reg       <= 1'b0;
                core_reset_reg <= 1'b1;
            end
            if (ld_bank) begin
                bank_lat_reg <= rx_byte_i[BankWidth-1:0];
            end
            if (ld_len_lo) begin
                len_lo_reg <= rx_byte_i;
            end
            if (ld_len) begin
                // The sum is cleared even for empty frames, whose checksum is 0.
                words_left_reg <= len_full;
                addr_cnt_reg   <= '0;
                byte_cnt_reg   <= '0;
                word_reg       <= '0;
                sum_reg        <= '0;
            end
            if (data_byte) begin
                word_reg <= word_merged;
                sum_reg  <= sum_reg + rx_byte_i;
                if (last_lane) begin
                    // Explicit wrap so that word widths with a byte count
                    // that is not a power of two also work.
                    byte_cnt_reg   <= '0;
                    we_reg         <= 1'b1;
                    bank_out_reg   <= bank_lat_reg;
                    addr_out_reg   <= addr_cnt_reg;
                    wdata_out_reg  <= word_merged;
                    addr_cnt_reg   <= addr_cnt_reg + 1'b1;
                    words_left_reg <= words_left_reg - 16'd1;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end
            if (frame_ok) begin
                done_reg <= 1'b1;
            end
            if (release_core) begin
                core_reset_reg <= 1'b0;
            end
            if (in_err) begin
                err_reg        <= 1'b1;
                core_reset_reg <= 1'b1;
                done_reg       <= 1'b0;
            end
        end
    end

    assign we_o         = we_reg;
    assign bank_o       = bank_out_reg;
    assign addr_o       = addr_out_reg;
    assign wdata_o      = wdata_out_reg;
    assign core_reset_o = core_reset_reg;
    assign done_o       = done_reg;
    assign err_o        = err_reg;

endmodule
